// File: rtl/ex_memory_request_unit_pkg.sv
// Shared constants and queue-entry type for the execute-stage memory request unit.
package memory_request_params;

    // Bit positions inside the one-hot io_type {word,left,half,right,byte}
    localparam int unsigned IO_BYTE  = 0;
    localparam int unsigned IO_RIGHT = 1;
    localparam int unsigned IO_HALF  = 2;
    localparam int unsigned IO_LEFT  = 3;
    localparam int unsigned IO_WORD  = 4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       write;
        logic [4:0] io_type;
        logic [1:0] offset;
        logic       cancelled;
    } outstanding_entry_t;

endpackage

// File: rtl/ex_memory_request_unit_outstanding_fifo.sv
// In-order queue of issued memory ops awaiting their data phase; cancel_all_i
// marks every stored entry cancelled so its response is swallowed.
module outstanding_fifo
    import memory_request_params::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           push_i,
    input  outstanding_entry_t             push_entry_i,
    input  logic                           pop_i,
    input  logic                           cancel_all_i,
    output logic                           head_valid_o,
    output outstanding_entry_t             head_entry_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    outstanding_entry_t mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // A push lands after the broadcast cancel, so it carries its own cancelled flag
    always_ff @(posedge clock_i) begin
        if (cancel_all_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i].cancelled <= 1'b1;
            end
        end
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_valid_o = (count_q != '0);
    assign head_entry_o = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/ex_memory_request_unit.sv
// Execute-stage data-memory front end: formats and issues one op per handshake, tracks outstanding ops.
// Optional misalignment trap enabled by defining DATA_RAM_ALIGN_CHECK_EN.
module ex_memory_request_unit
    import memory_request_params::*;
#(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned OUTSTANDING_DEPTH = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   request_valid,
    output logic                                   request_ready,
    input  logic                                   request_write,
    input  logic [4:0]                             request_io_type,
    input  logic [ADDR_WIDTH-1:0]                  request_address,
    input  logic [31:0]                            request_write_data,
    input  logic                                   flush,
    output logic                                   address_error,
    output logic                                   data_ram_request,
    output logic                                   data_ram_write,
    output logic [1:0]                             data_ram_size,
    output logic [ADDR_WIDTH-1:0]                  data_ram_address,
    output logic [31:0]                            data_ram_write_data,
    output logic [3:0]                             data_ram_write_strobe,
    input  logic                                   data_ram_address_ready,
    input  logic                                   data_ram_data_ready,
    input  logic [31:0]                            data_ram_read_data,
    output logic                                   response_valid,
    output logic                                   response_is_write,
    output logic [4:0]                             response_io_type,
    output logic [1:0]                             response_offset,
    output logic [31:0]                            response_data,
    output logic [$clog2(OUTSTANDING_DEPTH+1)-1:0] outstanding_count
);

    localparam int unsigned COUNT_WIDTH = $clog2(OUTSTANDING_DEPTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  req_q, req_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            strobe_q, strobe_d;
    logic [4:0]            io_q, io_d;
    logic [1:0]            off_q, off_d;

    logic [1:0]            req_off;
    logic [1:0]            fmt_size;
    logic [ADDR_WIDTH-1:0] fmt_addr;
    logic [31:0]           fmt_wdata;
    logic [3:0]            fmt_strobe;
    logic                  accept;
    logic                  misaligned;
    logic                  push;
    logic                  head_valid;
    outstanding_entry_t    head_entry;
    outstanding_entry_t    push_entry;
    logic [COUNT_WIDTH-1:0] count;

    assign req_off       = request_address[1:0];
    assign request_ready = !reset && (state_q == ST_IDLE)
                           && (count < COUNT_WIDTH'(OUTSTANDING_DEPTH)) && !flush;
    assign accept        = request_valid && request_ready;

`ifdef DATA_RAM_ALIGN_CHECK_EN
    assign misaligned = (request_io_type[IO_WORD] && (req_off != 2'b00))
                        || (request_io_type[IO_HALF] && req_off[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign address_error = accept && misaligned;

    // Left/right shifts use ~offset, which equals 3-offset for a 2-bit offset
    always_comb begin
        fmt_size   = SIZE_WORD;
        fmt_addr   = request_address;
        fmt_strobe = 4'b1111;
        fmt_wdata  = request_write_data;
        if (request_io_type[IO_BYTE]) begin
            fmt_size   = SIZE_BYTE;
            fmt_strobe = 4'b0001 << req_off;
            fmt_wdata  = {4{request_write_data[7:0]}};
        end else if (request_io_type[IO_HALF]) begin
            fmt_size   = SIZE_HALF;
            fmt_strobe = req_off[1] ? 4'b1100 : 4'b0011;
            fmt_wdata  = {2{request_write_data[15:0]}};
        end else if (request_io_type[IO_LEFT]) begin
            fmt_addr   = {request_address[ADDR_WIDTH-1:2], 2'b00};
            fmt_strobe = 4'b1111 >> (~req_off);
            fmt_wdata  = request_write_data >> {~req_off, 3'b000};
        end else if (request_io_type[IO_RIGHT]) begin
            fmt_addr   = {request_address[ADDR_WIDTH-1:2], 2'b00};
            fmt_strobe = 4'b1111 << req_off;
            fmt_wdata  = request_write_data << {req_off, 3'b000};
        end
        if (!request_write) begin
            fmt_strobe = '0;
            fmt_wdata  = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        write_d  = write_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strobe_d = strobe_q;
        io_d     = io_q;
        off_d    = off_q;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && !misaligned) begin
                    state_d  = ST_ISSUE;
                    req_d    = 1'b1;
                    write_d  = request_write;
                    size_d   = fmt_size;
                    addr_d   = fmt_addr;
                    wdata_d  = fmt_wdata;
                    strobe_d = fmt_strobe;
                    io_d     = request_io_type;
                    off_d    = req_off;
                end
            end
            ST_ISSUE: begin
                if (data_ram_address_ready) begin
                    push     = 1'b1;
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    write_d  = 1'b0;
                    size_d   = '0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    strobe_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            io_q     <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            write_q  <= write_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            io_q     <= io_d;
            off_q    <= off_d;
        end
    end

    // An op whose address phase completes during a flush is recorded already cancelled
    assign push_entry = '{write: write_q, io_type: io_q, offset: off_q, cancelled: flush};

    outstanding_fifo #(
        .DEPTH(OUTSTANDING_DEPTH)
    ) u_outstanding_fifo (
        .clock_i      (clock),
        .reset_i      (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (data_ram_data_ready),
        .cancel_all_i (flush),
        .head_valid_o (head_valid),
        .head_entry_o (head_entry),
        .count_o      (count)
    );

    assign data_ram_request      = req_q;
    assign data_ram_write        = write_q;
    assign data_ram_size         = size_q;
    assign data_ram_address      = addr_q;
    assign data_ram_write_data   = wdata_q;
    assign data_ram_write_strobe = strobe_q;

    assign response_valid    = !reset && data_ram_data_ready && head_valid && !head_entry.cancelled;
    assign response_is_write = head_entry.write;
    assign response_io_type  = head_entry.io_type;
    assign response_offset   = head_entry.offset;
    assign response_data     = data_ram_read_data;
    assign outstanding_count = count;

endmodule
